// File: rtl/char_cnt_timer.sv
// Character-count timer: counts qualifying UART bytes up to a target and
// reports how many clock cycles the measurement took, with an optional timeout.
module char_cnt_timer #(
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned TIME_W      = 32,
   parameter int unsigned TIMEOUT_CYC = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [CNT_W-1:0]  target_cnt,
   input  logic              match_en,
   input  logic [7:0]        match_char,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              busy,
   output logic              done,
   output logic              done_pulse,
   output logic              timeout,
   output logic [CNT_W-1:0]  char_count,
   output logic [TIME_W-1:0] elapsed
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_COUNT,
      S_DONE,
      S_TIMEOUT
   } state_t;

   localparam logic              TO_EN   = (TIMEOUT_CYC != 0);
   localparam logic [TIME_W-1:0] TO_VAL  = TIME_W'(TIMEOUT_CYC);
   localparam logic [TIME_W-1:0] TO_LAST = TIME_W'(TIMEOUT_CYC - 1);
   localparam logic [TIME_W-1:0] EL_MAX  = {TIME_W{1'b1}};

   state_t              state_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [TIME_W-1:0]   el_q;
   logic [CNT_W-1:0]    target_q;
   logic                men_q;
   logic [7:0]          mchar_q;
   logic                busy_q;
   logic                done_q;
   logic                pulse_q;
   logic                timeout_q;

   logic                qualify;
   logic                cnt_inc;
   logic                complete;
   logic                to_hit;
   logic [CNT_W-1:0]    cnt_d;
   logic [TIME_W-1:0]   el_d;

   // NOTE: every signal is assigned unconditionally here, so no latch can be inferred.
   always_comb begin
      qualify  = rx_valid && (!men_q || (rx_data == mchar_q));
      cnt_d    = cnt_q + CNT_W'(1);
      // A zero target finishes on the first COUNT edge without counting anything.
      cnt_inc  = qualify && (target_q != '0);
      complete = (target_q == '0) || (qualify && (cnt_d == target_q));
      to_hit   = TO_EN && (el_q == TO_LAST);
      el_d     = (el_q == EL_MAX) ? el_q : el_q + TIME_W'(1);
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         el_q      <= '0;
         target_q  <= '0;
         men_q     <= 1'b0;
         mchar_q   <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         pulse_q   <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         pulse_q <= 1'b0;
         if (start) begin
            state_q   <= S_COUNT;
            cnt_q     <= '0;
            el_q      <= '0;
            target_q  <= target_cnt;
            men_q     <= match_en;
            mchar_q   <= match_char;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
         end else begin
            unique case (state_q)
               S_COUNT: begin
                  if (cnt_inc) cnt_q <= cnt_d;
                  // Completion outranks timeout; elapsed freezes on the completing edge.
                  if (complete) begin
                     state_q <= S_DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     pulse_q <= 1'b1;
                  end else if (to_hit) begin
                     state_q   <= S_TIMEOUT;
                     busy_q    <= 1'b0;
                     timeout_q <= 1'b1;
                     el_q      <= TO_VAL;
                  end else begin
                     el_q <= el_d;
                  end
               end
               S_IDLE, S_DONE, S_TIMEOUT: begin
                  state_q <= state_q;
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign done_pulse = pulse_q;
   assign timeout    = timeout_q;
   assign char_count = cnt_q;
   assign elapsed    = el_q;

`ifndef SYNTHESIS
   status_exclusive: assert property (@(posedge clk) $onehot0({busy_q, done_q, timeout_q}));
`endif

endmodule

// File: tb/tb_char_cnt_timer.sv
// Bench for char_cnt_timer: three instances (no timeout, TIMEOUT_CYC=10, 4-bit timer)
// share directed stimulus and are compared every cycle against a measurement-level model.
module tb_char_cnt_timer;

   logic        clk = 1'b0;
   logic        rst, start, match_en, rx_valid;
   logic [15:0] target_cnt;
   logic [7:0]  match_char, rx_data;

   logic [2:0]  busy_v, done_v, pulse_v, to_v;
   logic [15:0] cnt_a, cnt_t, cnt_s;
   logic [31:0] el_a, el_t;
   logic [3:0]  el_s;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   char_cnt_timer #(.CNT_W(16), .TIME_W(32), .TIMEOUT_CYC(0)) dut_a (
      .clk(clk), .rst(rst), .start(start), .target_cnt(target_cnt), .match_en(match_en),
      .match_char(match_char), .rx_valid(rx_valid), .rx_data(rx_data), .busy(busy_v[0]),
      .done(done_v[0]), .done_pulse(pulse_v[0]), .timeout(to_v[0]), .char_count(cnt_a),
      .elapsed(el_a));

   char_cnt_timer #(.CNT_W(16), .TIME_W(32), .TIMEOUT_CYC(10)) dut_t (
      .clk(clk), .rst(rst), .start(start), .target_cnt(target_cnt), .match_en(match_en),
      .match_char(match_char), .rx_valid(rx_valid), .rx_data(rx_data), .busy(busy_v[1]),
      .done(done_v[1]), .done_pulse(pulse_v[1]), .timeout(to_v[1]), .char_count(cnt_t),
      .elapsed(el_t));

   char_cnt_timer #(.CNT_W(16), .TIME_W(4), .TIMEOUT_CYC(0)) dut_s (
      .clk(clk), .rst(rst), .start(start), .target_cnt(target_cnt), .match_en(match_en),
      .match_char(match_char), .rx_valid(rx_valid), .rx_data(rx_data), .busy(busy_v[2]),
      .done(done_v[2]), .done_pulse(pulse_v[2]), .timeout(to_v[2]), .char_count(cnt_s),
      .elapsed(el_s));

   // Model: a measurement is described by when it started, how many bytes matched,
   // how it ended and at which edge; elapsed while running is just cycles since start.
   localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2, M_TO = 3;

   typedef struct {
      int         st;
      longint     s_cyc;
      longint     e_cyc;
      longint     count;
      longint     frozen;
      longint     target;
      bit         men;
      logic [7:0] mch;
   } mdl_t;

   mdl_t   m [3];
   longint to_cyc [3] = '{0, 10, 0};
   longint tmax   [3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 15};
   longint cyc = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic model_edge(input int i);
      longint k, eln;
      bit     q;
      if (rst) begin
         m[i] = '{default: 0};
         m[i].e_cyc = -10;
      end else if (start) begin
         m[i].st     = M_RUN;
         m[i].s_cyc  = cyc;
         m[i].count  = 0;
         m[i].target = target_cnt;
         m[i].men    = match_en;
         m[i].mch    = match_char;
      end else if (m[i].st == M_RUN) begin
         k   = cyc - m[i].s_cyc - 1;
         eln = (k > tmax[i]) ? tmax[i] : k;
         q   = rx_valid && (!m[i].men || rx_data == m[i].mch);
         if (m[i].target == 0 || (q && m[i].count + 1 == m[i].target)) begin
            if (m[i].target != 0) m[i].count++;
            m[i].st     = M_DONE;
            m[i].frozen = eln;
            m[i].e_cyc  = cyc;
         end else begin
            if (q) m[i].count++;
            if (to_cyc[i] > 0 && k == to_cyc[i] - 1) begin
               m[i].st     = M_TO;
               m[i].frozen = to_cyc[i];
            end
         end
      end
   endtask

   function automatic logic [63:0] exp_el(input int i);
      longint k;
      if (m[i].st != M_RUN) return m[i].frozen;
      k = cyc - m[i].s_cyc - 1;
      return (k > tmax[i]) ? tmax[i] : k;
   endfunction

   function automatic logic [63:0] dut_cnt(input int i);
      case (i)
         0:       return {48'b0, cnt_a};
         1:       return {48'b0, cnt_t};
         default: return {48'b0, cnt_s};
      endcase
   endfunction

   function automatic logic [63:0] dut_el(input int i);
      case (i)
         0:       return {32'b0, el_a};
         1:       return {32'b0, el_t};
         default: return {60'b0, el_s};
      endcase
   endfunction

   always @(posedge clk) begin
      for (int i = 0; i < 3; i++) model_edge(i);
      cyc++;
   end

   always @(negedge clk) begin
      if (cyc >= 1) begin
         for (int i = 0; i < 3; i++) begin
            check($sformatf("u%0d busy", i),    busy_v[i],  m[i].st == M_RUN);
            check($sformatf("u%0d done", i),    done_v[i],  m[i].st == M_DONE);
            check($sformatf("u%0d pulse", i),   pulse_v[i], m[i].st == M_DONE && m[i].e_cyc == cyc - 1);
            check($sformatf("u%0d timeout", i), to_v[i],    m[i].st == M_TO);
            check($sformatf("u%0d count", i),   dut_cnt(i), m[i].count);
            check($sformatf("u%0d elapsed", i), dut_el(i),  exp_el(i));
         end
      end
   end

   task automatic cyc_in(input bit r, input bit st, input bit rv, input logic [7:0] rd);
      rst      = r;
      start    = st;
      rx_valid = rv;
      rx_data  = rd;
      @(negedge clk);
   endtask

   task automatic cfg(input logic [15:0] t, input bit me, input logic [7:0] mc);
      target_cnt = t;
      match_en   = me;
      match_char = mc;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not end (cycle %0d)", cyc);
      $fatal(1);
   end

   initial begin
      rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = '0;
      cfg(16'd7, 1'b1, 8'hAA);
      @(negedge clk);
      cyc_in(1, 1, 1, 8'hAA);
      cyc_in(0, 0, 0, 8'h00);
      check("reset busy", busy_v, 0);
      check("reset done", done_v, 0);
      check("reset pulse", pulse_v, 0);
      check("reset timeout", to_v, 0);
      check("reset count", cnt_a, 0);
      check("reset elapsed", el_a, 0);

      // Three unfiltered bytes at cycles 2, 5, 9 after a start at cycle 0.
      cfg(16'd3, 1'b0, 8'h00);
      cyc_in(0, 1, 0, 8'h00);
      for (int c = 1; c <= 9; c++) cyc_in(0, 0, (c == 2 || c == 5 || c == 9), 8'h55);
      check("r036 pulse", pulse_v[0], 1);
      check("r036 count", cnt_a, 3);
      check("r036 elapsed", el_a, 8);
      check("r036 timeout unit elapsed", el_t, 8);
      cyc_in(0, 0, 1, 8'h55);
      check("r036 pulse drops", pulse_v[0], 0);
      check("r036 done holds count", cnt_a, 3);

      // Filtered: only 0x3A counts; inputs changed after start must not matter.
      cfg(16'd2, 1'b1, 8'h3A);
      cyc_in(0, 1, 0, 8'h00);
      cfg(16'd9, 1'b0, 8'h41);
      cyc_in(0, 0, 1, 8'h41);
      cyc_in(0, 0, 1, 8'h3A);
      cyc_in(0, 0, 1, 8'h42);
      check("r037 mid count", cnt_a, 1);
      check("r037 mid busy", busy_v[0], 1);
      cyc_in(0, 0, 1, 8'h3A);
      check("r037 pulse", pulse_v[0], 1);
      check("r037 count", cnt_a, 2);
      check("r037 elapsed", el_a, 3);

      // Zero target finishes on the first COUNT edge even with a byte present.
      cfg(16'd0, 1'b0, 8'h00);
      cyc_in(0, 1, 0, 8'h00);
      check("r041 busy", busy_v[0], 1);
      cyc_in(0, 0, 1, 8'h10);
      check("r041 pulse", pulse_v[0], 1);
      check("r041 count", cnt_a, 0);
      check("r041 elapsed", el_a, 0);

      // Timeout: target 5, only two bytes.
      cfg(16'd5, 1'b0, 8'h00);
      cyc_in(0, 1, 0, 8'h00);
      for (int c = 1; c <= 10; c++) cyc_in(0, 0, (c == 3 || c == 6), 8'h20);
      check("r038 timeout", to_v[1], 1);
      check("r038 elapsed", el_t, 10);
      check("r038 count", cnt_t, 2);
      check("r038 done", done_v[1], 0);
      check("r038 no-timeout unit busy", busy_v[0], 1);
      cyc_in(0, 0, 1, 8'h20);
      check("r038 ignores rx", cnt_t, 2);

      // Completion on the very edge that would time out; also restarts from TIMEOUT.
      cfg(16'd1, 1'b0, 8'h00);
      cyc_in(0, 1, 0, 8'h00);
      for (int c = 1; c <= 10; c++) cyc_in(0, 0, (c == 10), 8'h30);
      check("r039 done", done_v[1], 1);
      check("r039 timeout", to_v[1], 0);
      check("r039 elapsed", el_t, 9);

      // Reset mid-measurement outranks start and rx_valid.
      cfg(16'd10, 1'b0, 8'h00);
      cyc_in(0, 1, 0, 8'h00);
      for (int c = 1; c <= 4; c++) cyc_in(0, 0, 1, 8'h61);
      check("r040 pre-reset count", cnt_a, 4);
      cyc_in(1, 1, 1, 8'h61);
      check("r040 reset busy", busy_v, 0);
      check("r040 reset count", cnt_a, 0);
      check("r040 reset elapsed", el_a, 0);
      cyc_in(0, 0, 1, 8'h61);
      check("r040 idle ignores rx", cnt_a, 0);

      // Start mid-measurement restarts, ignoring the byte on that edge.
      cyc_in(0, 1, 0, 8'h00);
      for (int c = 1; c <= 4; c++) cyc_in(0, 0, 1, 8'h62);
      check("r040 pre-restart count", cnt_a, 4);
      cyc_in(0, 1, 1, 8'h62);
      check("r040 restart busy", busy_v[0], 1);
      check("r040 restart count", cnt_a, 0);
      check("r040 restart elapsed", el_a, 0);

      // Long measurement: the 4-bit timer must stick at 15.
      cfg(16'd100, 1'b0, 8'h00);
      cyc_in(0, 1, 0, 8'h00);
      for (int c = 1; c <= 20; c++) cyc_in(0, 0, (c % 7 == 0), 8'h70);
      check("sat elapsed narrow", el_s, 15);
      check("sat elapsed wide", el_a, 20);
      check("sat count", cnt_s, 2);
      cyc_in(0, 0, 0, 8'h00);
      check("sat holds", el_s, 15);

      for (int c = 0; c < 3; c++) cyc_in(0, 0, 0, 8'h00);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/char_cnt_timer.md
CHAR_CNT_TIMER -- requirements
Module: char_cnt_timer

Interface
REQ-001 Parameter CNT_W, default 16, SHALL set the width of the character counter and target.
REQ-002 Parameter TIME_W, default 32, SHALL set the width of the elapsed-cycle timer.
REQ-003 Parameter TIMEOUT_CYC, default 0, SHALL set the timeout limit in clk cycles; the value 0 SHALL disable timeout.
REQ-004 Port clk, input, 1 bit: clock; all logic is on the rising edge.
REQ-005 Port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 Port start, input, 1 bit: arm or restart a measurement.
REQ-007 Port target_cnt, input, CNT_W bits: number of qualifying characters to await; sampled on the start edge.
REQ-008 Port match_en, input, 1 bit: when 1, only characters equal to match_char qualify; sampled on the start edge.
REQ-009 Port match_char, input, 8 bits: filter byte; sampled on the start edge.
REQ-010 Port rx_valid, input, 1 bit: single-cycle strobe, one received UART byte.
REQ-011 Port rx_data, input, 8 bits: received byte, valid when rx_valid=1.
REQ-012 Port busy, output, 1 bit: high while in state COUNT.
REQ-013 Port done, output, 1 bit: high while in state DONE.
REQ-014 Port done_pulse, output, 1 bit: one-cycle strobe on entry to DONE.
REQ-015 Port timeout, output, 1 bit: high while in state TIMEOUT.
REQ-016 Port char_count, output, CNT_W bits: qualifying characters counted in the current or last measurement.
REQ-017 Port elapsed, output, TIME_W bits: cycle count of the current or last measurement.

Function
REQ-018 The block SHALL implement four states: IDLE, COUNT, DONE and TIMEOUT.
REQ-019 A qualifying character SHALL be defined as rx_valid=1 AND (latched match_en=0 OR rx_data equals latched match_char).
REQ-020 start=1 in any state SHALL, at that edge, select state COUNT, set char_count=0 and elapsed=0, and latch target_cnt, match_en and match_char.
REQ-021 start SHALL take priority over every other event; an rx_valid on the start edge SHALL be ignored.
REQ-022 In COUNT, a qualifying character SHALL increment char_count by 1 at that edge.
REQ-023 In COUNT, elapsed SHALL increment by 1 at each edge that neither completes nor starts a measurement.
REQ-024 Completion SHALL occur when char_count+1 equals the latched target on a qualifying edge; that edge SHALL select DONE, increment char_count and hold elapsed.
REQ-025 A character qualifying in the first COUNT cycle that completes the measurement SHALL yield elapsed=0; one in COUNT cycle n SHALL yield elapsed=n.
REQ-026 A latched target of 0 SHALL complete at the first COUNT edge regardless of rx_valid, with char_count=0 and elapsed=0.
REQ-027 With TIMEOUT_CYC>0, an edge in COUNT with elapsed=TIMEOUT_CYC-1 and no completion SHALL select TIMEOUT and set elapsed=TIMEOUT_CYC.
REQ-028 If completion and the timeout condition coincide on the same edge, completion SHALL win.
REQ-029 With TIMEOUT_CYC=0, elapsed SHALL saturate at all-ones and never wrap.
REQ-030 In IDLE, DONE and TIMEOUT, char_count and elapsed SHALL hold their values, and rx_valid SHALL be ignored.
REQ-031 done_pulse SHALL be high exactly in the first cycle after the completing edge.
REQ-032 busy, done and timeout SHALL be registered and mutually exclusive.

Reset
REQ-033 rst=1 SHALL, at the edge, select IDLE and clear char_count, elapsed, busy, done, done_pulse, timeout and the latched configuration to 0.
REQ-034 rst SHALL take priority over start and rx_valid, including mid-measurement.
REQ-035 All outputs SHALL read 0 in the first cycle after reset is released.

Verification
REQ-036 target=3, match_en=0, start at cycle 0, rx_valid at cycles 2, 5 and 9 -> done_pulse at cycle 10, char_count=3, elapsed=8.
REQ-037 target=2, match_en=1, match_char=0x3A, bytes 0x41, 0x3A, 0x42, 0x3A -> completes only on the second 0x3A with char_count=2.
REQ-038 TIMEOUT_CYC=10, target=5, only 2 characters sent -> timeout=1 after 10 COUNT cycles, elapsed=10, char_count=2, done=0.
REQ-039 TIMEOUT_CYC=10, completing character on the last COUNT cycle -> done=1, timeout=0, elapsed=9.
REQ-040 rst or start asserted mid-COUNT with char_count=4 -> next cycle, rst gives IDLE with all outputs 0; start gives COUNT with char_count=0 and elapsed=0.
REQ-041 target=0, start -> done_pulse one cycle after the first COUNT cycle, char_count=0, elapsed=0.
